// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester bridge.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Bus output values while preset_n is low
    localparam logic RST_PSEL    = 1'b0;
    localparam logic RST_PENABLE = 1'b0;
    localparam logic RST_PWRITE  = 1'b0;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; expired flags the last allowed wait cycle.
module apb_timeout_cnt #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = TO_EN && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer.
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | psel=1 penable=0, one cycle, wait counter cleared
//   ACCESS | psel=1 penable=1 until pready or timeout
//   RESP   | bus idle, response held until rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e state, state_nxt;
    logic       cnt_clr, cnt_en, timeout_hit;

    apb_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .expired  (timeout_hit)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Bus controls decode straight from state so reset drops them asynchronously
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        psel      = RST_PSEL;
        penable   = RST_PENABLE;
        rsp_valid = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                psel      = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (timeout_hit) state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address phase registers hold their last values between transfers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwrite <= RST_PWRITE;
            paddr  <= '0;
            pwdata <= '0;
        end else if ((state == ST_IDLE) && cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
        end
    end

    // pready wins over a timeout landing in the same cycle
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (pready) begin
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= pwrite ? '0 : prdata;
            end else if (timeout_hit) begin
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end
        end
    end

endmodule
